// File: rtl/qspinor_pkg.sv
// rtl/qspinor_pkg.sv - shared states, PHY encodings and helpers for the QSPI NOR read sequencer (QSPINOR_CONT_EN adds ST_EXIT)
package qspinor_pkg;

    localparam logic [1:0] WID_X1 = 2'd0;
    localparam logic [1:0] WID_X2 = 2'd1;
    localparam logic [1:0] WID_X4 = 2'd2;

    localparam logic DIR_TO_NOR   = 1'b1;
    localparam logic DIR_FROM_NOR = 1'b0;

    localparam logic [7:0] MODE_CONT = 8'hA0;
    localparam logic [7:0] MODE_NONE = 8'h00;
    localparam logic [7:0] EXIT_BYTE = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_RESP,
`ifdef QSPINOR_CONT_EN
        ST_CS_GAP,
        ST_EXIT
`else
        ST_CS_GAP
`endif
    } state_t;

    // Everything the PHY needs to hold steady from trig until done.
    typedef struct packed {
        logic [7:0] dout;
        logic       dir;
        logic [1:0] wid;
    } phy_beat_t;

    function automatic phy_beat_t mk_beat(input logic [7:0] dout, input logic dir,
                                          input logic [1:0] wid);
        phy_beat_t b;
        b.dout = dout;
        b.dir  = dir;
        b.wid  = wid;
        return b;
    endfunction

    // Flash expects the address MSB first.
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [2:0] idx);
        case (idx)
            3'd0:    return addr[23:16];
            3'd1:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/qspinor_rd_ctrl_if.sv
// rtl/qspinor_rd_ctrl_if.sv - request/response, PHY byte-engine and chip-select signals of the read sequencer
interface qspinor_rd_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        phy_trig;
    logic        phy_done;
    logic [7:0]  phy_dout;
    logic [7:0]  phy_din;
    logic        phy_dir;
    logic [1:0]  phy_wid;
    logic        nor_csn;

    modport master (
        input  req_valid, req_addr, req_len, phy_done, phy_din,
        output req_ready, rsp_valid, rsp_data, phy_trig, phy_dout, phy_dir, phy_wid, nor_csn
    );

    modport slave (
        output req_valid, req_addr, req_len, phy_done, phy_din,
        input  req_ready, rsp_valid, rsp_data, phy_trig, phy_dout, phy_dir, phy_wid, nor_csn
    );
endinterface

// File: rtl/qspinor_rd_ctrl.sv
// rtl/qspinor_rd_ctrl.sv - Fast Read Quad I/O sequencer over a byte PHY; QSPINOR_CONT_EN enables continuous-read (XIP) mode
module qspinor_rd_ctrl
    import qspinor_pkg::*;
#(
    parameter logic [7:0] CMD_QREAD    = 8'hEB,
    parameter int         DUMMY_BYTES  = 2,
    parameter int         CSN_HIGH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    qspinor_rd_ctrl_if.master bus
);

`ifdef QSPINOR_CONT_EN
    localparam logic [7:0] MODE_BYTE = MODE_CONT;
    localparam state_t     RST_STATE = ST_EXIT;
`else
    localparam logic [7:0] MODE_BYTE = MODE_NONE;
    localparam state_t     RST_STATE = ST_IDLE;
`endif
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_BYTES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(CSN_HIGH_CYC);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  len_q, len_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        trig_q, trig_d;
    phy_beat_t   beat_q, beat_d;
    logic        csn_q, csn_d;
    logic        skip_cmd;
    logic        done_ok;
    logic        accept;

`ifdef QSPINOR_CONT_EN
    logic cont_q, cont_d;
    assign skip_cmd = cont_q;
`else
    assign skip_cmd = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        addr_d      = addr_q;
        len_d       = len_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        trig_d      = 1'b0;
        beat_d      = beat_q;
        csn_d       = csn_q;
`ifdef QSPINOR_CONT_EN
        cont_d      = cont_q;
`endif
        // A done in the trig cycle cannot belong to this byte, so it is ignored.
        done_ok = bus.phy_done && !trig_q;
        accept  = bus.req_valid && ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = bus.req_addr;
                    len_d      = bus.req_len;
                    rsp_data_d = '0;
                    csn_d      = 1'b0;
                    state_d    = ST_CS_SETUP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                cnt_d  = 3'd0;
                trig_d = 1'b1;
                if (skip_cmd) begin
                    beat_d  = mk_beat(addr_byte(addr_q, 3'd0), DIR_TO_NOR, WID_X4);
                    state_d = ST_ADDR;
                end else begin
                    beat_d  = mk_beat(CMD_QREAD, DIR_TO_NOR, WID_X1);
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (done_ok) begin
                    cnt_d   = 3'd0;
                    trig_d  = 1'b1;
                    beat_d  = mk_beat(addr_byte(addr_q, 3'd0), DIR_TO_NOR, WID_X4);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (done_ok) begin
                    trig_d = 1'b1;
                    if (cnt_q == 3'd2) begin
                        beat_d  = mk_beat(MODE_BYTE, DIR_TO_NOR, WID_X4);
                        state_d = ST_MODE;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        beat_d = mk_beat(addr_byte(addr_q, cnt_q + 3'd1), DIR_TO_NOR, WID_X4);
                    end
                end
            end
            ST_MODE: begin
                if (done_ok) begin
                    cnt_d   = 3'd0;
                    trig_d  = 1'b1;
                    beat_d  = mk_beat(8'h00, DIR_FROM_NOR, WID_X4);
                    state_d = ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                if (done_ok) begin
                    trig_d = 1'b1;
                    beat_d = mk_beat(8'h00, DIR_FROM_NOR, WID_X4);
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                if (done_ok) begin
                    rsp_data_d[{cnt_q[1:0], 3'b000} +: 8] = bus.phy_din;
                    if (cnt_q == {1'b0, len_q}) begin
                        rsp_valid_d = 1'b1;
                        csn_d       = 1'b1;
                        gap_d       = 4'd1;
                        state_d     = ST_RESP;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        trig_d = 1'b1;
                        beat_d = mk_beat(8'h00, DIR_FROM_NOR, WID_X4);
                    end
                end
            end
            ST_RESP: begin
`ifdef QSPINOR_CONT_EN
                cont_d = 1'b1;
`endif
                gap_d   = gap_q + 4'd1;
                state_d = ST_CS_GAP;
            end
            ST_CS_GAP: begin
                // gap_q counts cycles since nor_csn rose, that cycle being 1.
                if (gap_q >= GAP_LAST) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
`ifdef QSPINOR_CONT_EN
            ST_EXIT: begin
                // cnt_q steps: 0 drop csn, 1 launch the release byte, 2 wait for it.
                case (cnt_q)
                    3'd0: begin
                        csn_d = 1'b0;
                        cnt_d = 3'd1;
                    end
                    3'd1: begin
                        trig_d = 1'b1;
                        beat_d = mk_beat(EXIT_BYTE, DIR_TO_NOR, WID_X4);
                        cnt_d  = 3'd2;
                    end
                    default: begin
                        if (done_ok) begin
                            csn_d   = 1'b1;
                            gap_d   = 4'd1;
                            state_d = ST_CS_GAP;
                        end
                    end
                endcase
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= 3'd0;
            gap_q       <= 4'd0;
            addr_q      <= 24'd0;
            len_q       <= 2'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            trig_q      <= 1'b0;
            beat_q      <= mk_beat(8'h00, DIR_TO_NOR, WID_X1);
            csn_q       <= 1'b1;
`ifdef QSPINOR_CONT_EN
            cont_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            trig_q      <= trig_d;
            beat_q      <= beat_d;
            csn_q       <= csn_d;
`ifdef QSPINOR_CONT_EN
            cont_q      <= cont_d;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.phy_trig  = trig_q;
    assign bus.phy_dout  = beat_q.dout;
    assign bus.phy_dir   = beat_q.dir;
    assign bus.phy_wid   = beat_q.wid;
    assign bus.nor_csn   = csn_q;

endmodule

// File: tb/tb_qspinor_rd_ctrl.sv
// tb/tb_qspinor_rd_ctrl.sv - self-checking bench for qspinor_rd_ctrl with a PHY/flash model (QSPINOR_CONT_EN aware)
module tb_qspinor_rd_ctrl;

    localparam int DUMMY   = 2;
    localparam int GAP_MIN = 4;
`ifdef QSPINOR_CONT_EN
    localparam logic [7:0] MODE_EXP = 8'hA0;
    localparam bit         CONT     = 1'b1;
`else
    localparam logic [7:0] MODE_EXP = 8'h00;
    localparam bit         CONT     = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] dout;
        logic       dir;
        logic [1:0] wid;
    } beat_t;

    logic clk;
    logic rst;

    qspinor_rd_ctrl_if bus ();
    qspinor_rd_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          trig_cnt = 0;
    int          rsp_cnt = 0;
    int          high_run = 0;
    int          gap_at_fall = 0;
    int          dir0_idx = 0;
    int          data_done = 0;
    int          delay = 0;
    int unsigned dmin = 2;
    int unsigned dmax = 6;
    bit          busy = 1'b0;
    bit          prev_csn = 1'b1;
    bit          trig_busy_bad = 1'b0;
    bit          stab_bad = 1'b0;
    bit          ready_bad = 1'b0;
    bit          csn_rsp_bad = 1'b0;
    bit          cont_model = 1'b0;
    logic [31:0] last_rsp = 32'd0;
    beat_t       cur;
    beat_t       log_q[$];
    beat_t       exp_q[$];
    logic [7:0]  flash_q[$];

    function automatic beat_t mkb(input logic [7:0] d, input logic dir, input logic [1:0] wid);
        beat_t b;
        b.dout = d;
        b.dir  = dir;
        b.wid  = wid;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // PHY + flash model and bus monitor, all sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            busy         = 1'b0;
            bus.phy_done = 1'b0;
            bus.phy_din  = 8'h00;
        end else begin
            if (bus.phy_done) begin
                bus.phy_done = 1'b0;
                busy         = 1'b0;
            end
            if (bus.phy_trig) begin
                trig_cnt++;
                if (busy) trig_busy_bad = 1'b1;
                busy  = 1'b1;
                cur   = mkb(bus.phy_dout, bus.phy_dir, bus.phy_wid);
                log_q.push_back(cur);
                delay = int'($urandom_range(dmax, dmin));
            end else if (busy) begin
                if (mkb(bus.phy_dout, bus.phy_dir, bus.phy_wid) != cur) stab_bad = 1'b1;
                delay--;
                if (delay <= 0) begin
                    bus.phy_done = 1'b1;
                    bus.phy_din  = 8'($urandom);
                    if (!cur.dir) begin
                        if (dir0_idx >= DUMMY) begin
                            bus.phy_din = (flash_q.size() > 0) ? flash_q.pop_front() : 8'hEE;
                            data_done++;
                        end
                        dir0_idx++;
                    end
                end
            end
        end
        if (bus.rsp_valid === 1'b1) begin
            rsp_cnt++;
            last_rsp = bus.rsp_data;
            if (bus.nor_csn !== 1'b1) csn_rsp_bad = 1'b1;
        end
        if (bus.req_ready === 1'b1 && bus.nor_csn === 1'b0) ready_bad = 1'b1;
        if (bus.nor_csn === 1'b1) begin
            high_run++;
            dir0_idx  = 0;
            data_done = 0;
        end else begin
            if (prev_csn) gap_at_fall = high_run;
            high_run = 0;
        end
        prev_csn = (bus.nor_csn === 1'b1);
    end

    function automatic void build_exp(input logic [23:0] a, input logic [1:0] len, input bit cont);
        exp_q.delete();
        if (!cont) exp_q.push_back(mkb(8'hEB, 1'b1, 2'd0));
        for (int i = 2; i >= 0; i--) exp_q.push_back(mkb(8'((a >> (8 * i)) & 24'hFF), 1'b1, 2'd2));
        exp_q.push_back(mkb(MODE_EXP, 1'b1, 2'd2));
        for (int i = 0; i < DUMMY; i++) exp_q.push_back(mkb(8'h00, 1'b0, 2'd2));
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(mkb(8'h00, 1'b0, 2'd2));
    endfunction

    task automatic request(input logic [23:0] a, input logic [1:0] len, input bit drop, output bit ok);
        ok           = 1'b0;
        bus.req_addr = a;
        bus.req_len  = len;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (drop) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_cnt > base) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_exit();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ready_after_rst", 32'(ok), 32'd1);
`ifdef QSPINOR_CONT_EN
        check("exit_beats", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) check("exit_byte", 32'(log_q[0]), 32'(mkb(8'hFF, 1'b1, 2'd2)));
`else
        check("no_exit_beats", 32'(log_q.size()), 32'd0);
`endif
        log_q.delete();
    endtask

    task automatic do_read(input string tag, input logic [23:0] a, input logic [1:0] len,
                           input logic [31:0] word);
        logic [31:0] exp_word;
        int          t0, r0, exp_trigs, n;
        bit          ok;
        beat_t       obs;
        exp_word = 32'd0;
        for (int k = 0; k <= int'(len); k++) begin
            flash_q.push_back(word[8 * k +: 8]);
            exp_word = exp_word + ({24'd0, word[8 * k +: 8]} << (8 * k));
        end
        exp_trigs = (cont_model ? 0 : 1) + 3 + 1 + DUMMY + int'(len) + 1;
        build_exp(a, len, cont_model);
        log_q.delete();
        t0 = trig_cnt;
        r0 = rsp_cnt;
        ready_bad   = 1'b0;
        csn_rsp_bad = 1'b0;
        request(a, len, 1'b1, ok);
        check({tag, "_accept"}, 32'(ok), 32'd1);
        wait_rsp(r0, ok);
        check({tag, "_rsp_seen"}, 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        check({tag, "_rsp_data"}, last_rsp, exp_word);
        check({tag, "_rsp_pulses"}, 32'(rsp_cnt - r0), 32'd1);
        check({tag, "_trigs"}, 32'(trig_cnt - t0), 32'(exp_trigs));
        check({tag, "_beats"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            obs = log_q[i];
            if (!obs.dir) obs.dout = 8'h00;
            check($sformatf("%s_beat%0d", tag, i), 32'(obs), 32'(exp_q[i]));
        end
        check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
        check({tag, "_csn_at_rsp"}, 32'(csn_rsp_bad), 32'd0);
        cont_model = CONT;
    endtask

    initial begin
        bit ok;
        int r0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 24'd0;
        bus.req_len   = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_phy_trig", 32'(bus.phy_trig), 32'd0);
        check("rst_phy_dout", 32'(bus.phy_dout), 32'd0);
        check("rst_phy_dir", 32'(bus.phy_dir), 32'd1);
        check("rst_phy_wid", 32'(bus.phy_wid), 32'd0);
        check("rst_nor_csn", 32'(bus.nor_csn), 32'd1);
        log_q.delete();
        rst = 1'b0;
        expect_exit();

        do_read("rd4", 24'h012345, 2'd3, 32'h44332211);
        do_read("rd1_top", 24'hFFFFFF, 2'd0, 32'h0000005A);

        // Back-to-back with req_valid held across the first transaction.
        flash_q.push_back(8'hA1); flash_q.push_back(8'hB2);
        flash_q.push_back(8'hC3); flash_q.push_back(8'hD4);
        flash_q.push_back(8'h17); flash_q.push_back(8'h29);
        r0        = rsp_cnt;
        ready_bad = 1'b0;
        request(24'h100000, 2'd3, 1'b0, ok);
        check("b2b_accept_a", 32'(ok), 32'd1);
        bus.req_addr = 24'h200040;
        bus.req_len  = 2'd1;
        wait_rsp(r0, ok);
        check("b2b_rsp_a", 32'(ok), 32'd1);
        @(negedge clk);
        check("b2b_data_a", last_rsp, 32'hD4C3B2A1);
        check("b2b_ready_low", 32'(ready_bad), 32'd0);
        request(24'h200040, 2'd1, 1'b1, ok);
        check("b2b_accept_b", 32'(ok), 32'd1);
        wait_rsp(r0 + 1, ok);
        check("b2b_rsp_b", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        check("b2b_data_b", last_rsp, 32'h00002917);
        check("b2b_csn_gap", 32'(gap_at_fall >= GAP_MIN), 32'd1);
        cont_model = CONT;

        // Reset in the middle of DATA.
        flash_q.delete();
        flash_q.push_back(8'h01); flash_q.push_back(8'h02);
        flash_q.push_back(8'h03); flash_q.push_back(8'h04);
        r0 = rsp_cnt;
        request(24'h00ABCD, 2'd3, 1'b1, ok);
        check("rstd_accept", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (data_done >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstd_reach_data2", 32'(ok), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstd_csn", 32'(bus.nor_csn), 32'd1);
        check("rstd_trig", 32'(bus.phy_trig), 32'd0);
        check("rstd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstd_rsp_data", bus.rsp_data, 32'd0);
        @(negedge clk);
        flash_q.delete();
        log_q.delete();
        cont_model = 1'b0;
        rst = 1'b0;
        expect_exit();
        check("rstd_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        do_read("after_rst", 24'h00ABCD, 2'd2, 32'h00665544);

        // Randomized reads with slow, variable PHY latency.
        dmin = 5;
        dmax = 40;
        for (int n = 0; n < 6; n++) begin
            do_read($sformatf("rnd%0d", n), 24'($urandom), 2'($urandom), $urandom);
        end
        check("phy_stable", 32'(stab_bad), 32'd0);
        check("no_trig_busy", 32'(trig_busy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
